// File: rtl/alu_op_sequencer_if.sv
// Request, register-file and ALU bundle for the ALU op sequencer.
// master = sequencer side, slave = decode / datapath side.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              start;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] ra_idx;
  logic [REG_AW-1:0] rb_idx;
  logic [REG_AW-1:0] rd_idx;
  logic              busy;
  logic              done;
  logic              err;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  modport master (
    input  start, opcode, ra_idx, rb_idx, rd_idx,
    input  rf_rdata, alu_result,
    output busy, done, err,
    output rf_raddr, rf_we, rf_waddr, rf_wdata,
    output alu_op, alu_a, alu_b
  );

  modport slave (
    output start, opcode, ra_idx, rb_idx, rd_idx,
    output rf_rdata, alu_result,
    input  busy, done, err,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata,
    input  alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle register-to-register ALU sequencer.
// Reads A then B, executes on the ALU or shifts internally, writes back.
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int SHAMT_W = 5
) (
  input logic                 clk,
  input logic                 clr,
  alu_op_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXEC,
    S_SHIFT,
    S_WB
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   ra_q, ra_d;
  logic [REG_AW-1:0]   rb_q, rb_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   z_q, z_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;

  logic [REG_AW-1:0]   raddr_q, raddr_d;
  logic [3:0]          aluop_q, aluop_d;
  logic                we_q, we_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   z_sh;

  function automatic logic is_alu(input logic [3:0] o);
    return o <= 4'd5;
  endfunction

  function automatic logic is_shift(input logic [3:0] o);
    return (o >= 4'h8) && (o <= 4'hC);
  endfunction

  function automatic logic [DATA_W-1:0] shift1(
    input logic [3:0]        o,
    input logic [DATA_W-1:0] v
  );
    logic [DATA_W-1:0] r;
    case (o)
      4'h8:    r = {1'b0, v[DATA_W-1:1]};
      4'h9:    r = {v[DATA_W-1], v[DATA_W-1:1]};
      4'hA:    r = {v[DATA_W-2:0], 1'b0};
      4'hB:    r = {v[0], v[DATA_W-1:1]};
      4'hC:    r = {v[DATA_W-2:0], v[DATA_W-1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign shamt = bus.rf_rdata[SHAMT_W-1:0];
  assign z_sh  = shift1(op_q, z_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    y_d     = y_q;
    b_d     = b_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    raddr_d = '0;
    aluop_d = '0;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          if (is_alu(bus.opcode) || is_shift(bus.opcode)) begin
            op_d    = bus.opcode;
            ra_d    = bus.ra_idx;
            rb_d    = bus.rb_idx;
            rd_d    = bus.rd_idx;
            raddr_d = bus.ra_idx;
            busy_d  = 1'b1;
            state_d = S_RDA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RDA: begin
        y_d     = bus.rf_rdata;
        raddr_d = rb_q;
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d = bus.rf_rdata;
        if (is_alu(op_q)) begin
          aluop_d = op_q;
          state_d = S_EXEC;
        end else begin
          // zero count skips SHIFT and writes A back untouched
          z_d = y_q;
          if (shamt != '0) begin
            cnt_d   = shamt;
            state_d = S_SHIFT;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_EXEC: begin
        z_d     = bus.alu_result;
        state_d = S_WB;
      end
      S_SHIFT: begin
        z_d   = z_sh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = S_WB;
      end
      S_WB: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // writeback outputs are registered on entry to WB
    if (state_d == S_WB) begin
      we_d    = 1'b1;
      waddr_d = rd_q;
      wdata_d = z_d;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      aluop_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      y_q     <= y_d;
      b_q     <= b_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      aluop_q <= aluop_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.rf_raddr = raddr_q;
  assign bus.alu_op   = aluop_q;
  assign bus.alu_a    = y_q;
  assign bus.alu_b    = b_q;
  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a writeback scoreboard.
// Models the register file and ALU around the sequencer.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer_if #(.DATA_W(32), .REG_AW(4)) ifc ();

  alu_op_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  logic [31:0] rf [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (ifc.rf_we) rf[ifc.rf_waddr] <= ifc.rf_wdata;
    else if (pl_we) rf[pl_addr] <= pl_data;
  end

  assign ifc.rf_rdata = rf[ifc.rf_raddr];

  always_comb begin
    case (ifc.alu_op)
      4'd0:    ifc.alu_result = ifc.alu_a + ifc.alu_b;
      4'd1:    ifc.alu_result = ifc.alu_a - ifc.alu_b;
      4'd2:    ifc.alu_result = ifc.alu_a & ifc.alu_b;
      4'd3:    ifc.alu_result = ifc.alu_a | ifc.alu_b;
      4'd4:    ifc.alu_result = -ifc.alu_a;
      4'd5:    ifc.alu_result = ~ifc.alu_a;
      default: ifc.alu_result = '0;
    endcase
  end

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ifc.rf_we || ifc.done) check("done_eq_we", ifc.done, ifc.rf_we);
    if (ifc.rf_we) begin
      check("wb_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wb_addr", ifc.rf_waddr, e.rd);
        check("wb_data", ifc.rf_wdata, e.data);
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic setreg(input logic [3:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rd,
                       output int k);
    bit b0;
    bit ok;
    ok = 0;
    k  = cyc;
    ifc.opcode = op;
    ifc.ra_idx = ra;
    ifc.rb_idx = rb;
    ifc.rd_idx = rd;
    ifc.start  = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      b0 = ifc.busy;
      @(posedge clk);
      #1;
      if (!b0 && ifc.busy) begin
        ok = 1;
        k  = cyc;
      end
    end
    ifc.start = 1'b0;
    check("accept", 32'(ok), 1);
  endtask

  task automatic expect_wb(input logic [3:0] rd, input logic [31:0] d,
                           input int k, input int lat);
    sb.push_back('{rd: rd, data: d, cyc: k + lat - 1});
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ifc.busy) ok = 1;
    end
    check("drain", 32'(ok), 1);
  endtask

  initial begin
    int k1;
    int k2;
    ifc.start  = 1'b0;
    ifc.opcode = '0;
    ifc.ra_idx = '0;
    ifc.rb_idx = '0;
    ifc.rd_idx = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_err", ifc.err, 0);
    check("rst_we", ifc.rf_we, 0);
    check("rst_raddr", ifc.rf_raddr, 0);
    check("rst_alu_a", ifc.alu_a, 0);
    @(negedge clk);
    clr = 1'b0;

    setreg(1, 32'hAAAAAAAA);
    setreg(2, 32'h55555555);
    issue(4'd2, 1, 2, 3, k1);
    expect_wb(3, 32'h00000000, k1, 4);
    check("and_busy_k1", ifc.busy, 1);
    repeat (3) @(posedge clk);
    #1;
    check("and_busy_k4", ifc.busy, 1);
    check("and_done_k4", ifc.done, 1);
    @(posedge clk);
    #1;
    check("and_busy_k5", ifc.busy, 0);
    check("and_done_k5", ifc.done, 0);
    drain();
    check("rf_r3", rf[3], 32'h00000000);

    setreg(1, 32'hFFFFFFFF);
    setreg(2, 32'hABCD1234);
    setreg(5, 32'h00000037);
    setreg(6, 32'h00000073);
    issue(4'd2, 1, 2, 4, k1);
    expect_wb(4, 32'hABCD1234, k1, 4);
    issue(4'd2, 5, 6, 7, k2);
    expect_wb(7, 32'h00000033, k2, 4);
    check("b2b_gap", k2 - k1, 5);
    drain();

    issue(4'd0, 5, 6, 5, k1);
    expect_wb(5, 32'h000000AA, k1, 4);
    drain();
    check("alias_rd_ra", rf[5], 32'h000000AA);

    setreg(1, 32'h00000037);
    setreg(2, 32'h00000004);
    issue(4'hA, 1, 2, 8, k1);
    expect_wb(8, 32'h00000370, k1, 7);
    drain();

    setreg(1, 32'h80000000);
    setreg(2, 32'h0000001F);
    issue(4'h9, 1, 2, 9, k1);
    expect_wb(9, 32'hFFFFFFFF, k1, 34);
    drain();

    setreg(1, 32'h12345678);
    setreg(2, 32'hFFFFFFE0);
    issue(4'hB, 1, 2, 9, k1);
    expect_wb(9, 32'h12345678, k1, 3);
    drain();

    setreg(1, 32'h80000001);
    setreg(2, 32'h00000001);
    issue(4'hC, 1, 2, 9, k1);
    expect_wb(9, 32'h00000003, k1, 4);
    drain();

    ifc.opcode = 4'hF;
    ifc.start  = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    check("ill_err", ifc.err, 1);
    check("ill_busy", ifc.busy, 0);
    check("ill_raddr", ifc.rf_raddr, 0);
    @(posedge clk);
    #1;
    check("ill_err_pulse", ifc.err, 0);
    check("ill_busy2", ifc.busy, 0);

    setreg(1, 32'hF0000000);
    setreg(2, 32'h00000008);
    setreg(12, 32'h12121212);
    issue(4'h8, 1, 2, 11, k1);
    expect_wb(11, 32'h00F00000, k1, 11);
    repeat (3) @(posedge clk);
    #1;
    ifc.opcode = 4'd0;
    ifc.rd_idx = 4'd12;
    ifc.start  = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    drain();
    check("busy_start_ignored", rf[12], 32'h12121212);

    setreg(1, 32'h80000000);
    setreg(2, 32'h0000001F);
    setreg(10, 32'hDEADBEEF);
    issue(4'h9, 1, 2, 10, k1);
    repeat (5) @(posedge clk);
    #3 clr = 1'b1;
    #1;
    check("clr_busy", ifc.busy, 0);
    check("clr_we", ifc.rf_we, 0);
    check("clr_alu_a", ifc.alu_a, 0);
    check("clr_alu_b", ifc.alu_b, 0);
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    check("clr_no_wb", rf[10], 32'hDEADBEEF);
    check("clr_idle", ifc.busy, 0);

    setreg(1, 32'h00000007);
    setreg(2, 32'h00000009);
    issue(4'd0, 1, 2, 13, k1);
    expect_wb(13, 32'h00000010, k1, 4);
    drain();
    check("add_r13", rf[13], 32'h00000010);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that runs one register-to-register ALU instruction per request.
- Reads two source registers from the register file, drives the combinational ALU (AND/OR/ADD/SUB/NEG/NOT units), and executes shifts and rotates one bit per cycle internally.
- Writes the result back and pulses done.
- Sits between the instruction decode stage and the register file/ALU datapath.

Parameters:
DATA_W, 32, datapath width.
REG_AW, 4, register-file address width (16 registers).
SHAMT_W, 5, shift-count width; equals log2(DATA_W).

Ports:
clk  in  1  system clock, rising edge.
clr  in  1  asynchronous active-high reset.
start  in  1  request; sampled only in IDLE.
opcode  in  4  operation; sampled with start.
ra_idx  in  REG_AW  source A register index.
rb_idx  in  REG_AW  source B register index.
rd_idx  in  REG_AW  destination register index.
rf_raddr  out  REG_AW  register-file read address; read is combinational.
rf_rdata  in  DATA_W  register-file read data, valid in the same cycle as rf_raddr.
rf_we  out  1  register-file write enable.
rf_waddr  out  REG_AW  write address.
rf_wdata  out  DATA_W  write data.
alu_op  out  4  ALU function select.
alu_a  out  DATA_W  ALU operand A; always equals internal reg Y.
alu_b  out  DATA_W  ALU operand B; always equals internal reg B.
alu_result  in  DATA_W  combinational ALU result.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse during the writeback cycle.
err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset: clr high asynchronously forces IDLE and clears Y, B, Z, count, latched fields and all outputs to 0. Reset mid-operation aborts with no write.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NEG, 5 NOT: ALU ops, passed through on alu_op.
  - 8 SHR, 9 SHRA, A SHL, B ROR, C ROL: internal shift/rotate ops.
  - All other codes are illegal.
- States: IDLE, RDA, RDB, EXEC, SHIFT, WB.
- IDLE:
  - rf_raddr=0, alu_op=0, busy=0.
  - On start with a legal opcode: latch opcode, ra_idx, rb_idx and rd_idx, then go to RDA.
  - On start with an illegal opcode: err=1 next cycle, remain in IDLE, no register-file access.
- RDA: rf_raddr=ra; Y<=rf_rdata; go to RDB.
- RDB: rf_raddr=rb; B<=rf_rdata.
  - ALU op: go to EXEC.
  - Shift op with count=rf_rdata[SHAMT_W-1:0] nonzero: Z<=rf_rdata_A (Y), count<=that value, go to SHIFT.
  - Shift op with zero count: Z<=Y, go to WB.
  - Only the low SHAMT_W bits of B are the count; upper bits are ignored.
- EXEC: alu_op=latched opcode; Z<=alu_result; go to WB.
- SHIFT: once per cycle Z is shifted by 1 and count decrements.
  - SHR: zero fill. SHRA: sign-bit fill. SHL: zero fill. ROR/ROL: bit wraps around.
  - When count==1, the final shift is applied and the state goes to WB.
  - alu_op=0 throughout SHIFT.
- WB: rf_we=1, rf_waddr=rd, rf_wdata=Z, done=1; go to IDLE. No write occurs in any other state.
- Latency, with start accepted at edge k:
  - ALU op: WB cycle is k+4.
  - Shift with count n>0: WB cycle is k+3+n.
  - Shift with count 0: WB cycle is k+3.
  - Next start is accepted at the edge ending WB+1 (back-to-back issue gives a 5-cycle ALU throughput).
- Source/destination aliasing: rd may equal ra or rb. Operands are captured before WB, so the result is correct.
- start while busy is ignored; it is neither queued nor flagged.

Test Plan:
- R1=AAAAAAAA, R2=55555555, AND rd=R3 → R3=00000000; rf_we and done high exactly at k+4; busy high from k+1 to k+4.
- R1=FFFFFFFF, R2=ABCD1234, AND → ABCD1234. Then R1=00000037, R2=00000073 issued back-to-back → 00000033; second done 5 cycles after the first.
- SHL with R1=00000037, R2=00000004 → 00000370, WB at k+7. SHRA with 80000000 and count 31 → FFFFFFFF, WB at k+34.
- ROR with B=FFFFFFE0 (count 0) → rd=Y unchanged, WB at k+3. ROL of 80000001 by 1 → 00000003.
- Opcode F with start → err pulse for 1 cycle, busy stays 0, no rf_we. Start asserted during SHIFT → ignored, and the result is unaffected.
- clr asserted mid-SHIFT, asynchronously between edges → outputs 0 immediately, no writeback, IDLE. A subsequent ADD of 7 and 9 → 00000010.
